// File: rtl/alu_pipeline_hs.sv
// alu_pipeline_hs: a three-register, two-ALU arithmetic pipeline with valid/ready
// handshakes on both sides.
// Stage A computes t = op1 OPA op2, and stage B computes r = t OPB op1.
// A stage advances whenever it is empty or the stage after it advances, so
// bubbles collapse and backpressure ripples upstream within the same cycle.
// A flush drops every in-flight transaction. Reset does the same and also clears
// the data registers.
module alu_pipeline_hs #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  input  logic [1:0]        sela_i,
  input  logic [1:0]        selb_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic [1:0]        count_o
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // S1: input registers
  logic              s1_v;
  logic [DWIDTH-1:0] s1_op1;
  logic [DWIDTH-1:0] s1_op2;
  logic [1:0]        s1_sela;
  logic [1:0]        s1_selb;

  // S2: stage A result, plus the op1 that travels with its transaction
  logic              s2_v;
  logic [DWIDTH-1:0] s2_op1;
  logic [DWIDTH-1:0] s2_t;
  logic [1:0]        s2_selb;

  // S3: output register
  logic              s3_v;
  logic [DWIDTH-1:0] s3_r;

  logic adv1;
  logic adv2;
  logic adv3;
  logic in_fire;

  // Shared ALU. Every result wraps modulo 2^DWIDTH, and sub is a - b.
  function automatic logic [DWIDTH-1:0] alu(input logic [1:0] sel,
                                            input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] b);
    logic [DWIDTH-1:0] y;
    case (sel)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
    return y;
  endfunction

  // Ready chain from the output backwards: a stage may load if it is empty or its successor moves.
  always_comb begin
    adv3    = !s3_v || ready_i;
    adv2    = !s2_v || adv3;
    adv1    = !s1_v || adv2;
    ready_o = adv1 && !flush_i;
    in_fire = valid_i && ready_o;
  end

  // Valid bits: reset beats flush, and flush beats normal advance. A stage that loads takes its predecessor's valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else if (flush_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      if (adv1) s1_v <= in_fire;
      if (adv2) s2_v <= s1_v;
      if (adv3) s3_v <= s2_v;
    end
  end

  // Data path: S1 captures on an accepted input, and S2/S3 follow the advance chain. Values in invalid stages are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_op1  <= '0;
      s1_op2  <= '0;
      s1_sela <= '0;
      s1_selb <= '0;
      s2_op1  <= '0;
      s2_t    <= '0;
      s2_selb <= '0;
      s3_r    <= '0;
    end else begin
      if (in_fire) begin
        s1_op1  <= op1_i;
        s1_op2  <= op2_i;
        s1_sela <= sela_i;
        s1_selb <= selb_i;
      end
      if (adv2) begin
        s2_op1  <= s1_op1;
        s2_t    <= alu(s1_sela, s1_op1, s1_op2);
        s2_selb <= s1_selb;
      end
      if (adv3) begin
        s3_r <= alu(s2_selb, s2_t, s2_op1);
      end
    end
  end

  assign valid_o = s3_v;
  assign res_o   = s3_r;
  assign count_o = {1'b0, s1_v} + {1'b0, s2_v} + {1'b0, s3_v};

endmodule

// File: tb/tb_alu_pipeline_hs.sv
// tb_alu_pipeline_hs: scoreboard bench for alu_pipeline_hs at DWIDTH=8.
// Each accepted input pushes its expected result onto a queue. Each delivered
// output pops the oldest entry from the queue and compares against it.
module tb_alu_pipeline_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] op1_i;
  logic [7:0] op2_i;
  logic [1:0] sela_i;
  logic [1:0] selb_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] res_o;
  logic [1:0] count_o;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  logic [7:0] ia[5];
  logic [7:0] ib[5];
  logic [1:0] sa[5];
  logic [1:0] sb[5];

  alu_pipeline_hs #(.DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op1_i(op1_i), .op2_i(op2_i), .sela_i(sela_i), .selb_i(selb_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference op table: 00 add, 01 sub, 10 and, 11 xor.
  function automatic logic [7:0] refOp(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [7:0] refResult(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] s1, input logic [1:0] s2);
    return refOp(s2, refOp(s1, a, b), a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] s1, input logic [1:0] s2,
                               input logic rdy, input logic fl, input logic rn);
    valid_i = v;
    op1_i   = a;
    op2_i   = b;
    sela_i  = s1;
    selb_i  = s2;
    ready_i = rdy;
    flush_i = fl;
    rst     = rn;
    #1;
  endtask

  // Score the handshakes that will complete at the coming edge, then advance to the next falling edge.
  task automatic step();
    if (rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) checkOutput("spurious_valid", 32'(valid_o), 32'd0);
      else checkOutput("result", 32'(res_o), 32'(exp_q.pop_front()));
    end
    if (rst && valid_i && ready_o) exp_q.push_back(refResult(op1_i, op2_i, sela_i, selb_i));
    if (!rst || flush_i) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, rdy, 1'b0, 1'b1);
    step();
  endtask

  task automatic drain(input string tag, input int maxc);
    for (int i = 0; i < maxc && exp_q.size() > 0; i++) idle(1'b1);
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // 1. Reset held two cycles with valid_i high
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'h11, 8'h22, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
      step();
    end
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_res", 32'(res_o), 32'd0);
    checkOutput("rst_count", 32'(count_o), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    step();

    // 2. Single transaction: latency and pulse width
    applyStimulus(1'b1, 8'h05, 8'h03, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1);
    checkOutput("single_ready", 32'(ready_o), 32'd1);
    step();
    checkOutput("lat_k", 32'(valid_o), 32'd0);
    idle(1'b1);
    checkOutput("lat_k1", 32'(valid_o), 32'd0);
    idle(1'b1);
    checkOutput("lat_k2", 32'(valid_o), 32'd1);
    checkOutput("single_res", 32'(res_o), 32'h03);
    idle(1'b1);
    checkOutput("single_width", 32'(valid_o), 32'd0);
    checkOutput("single_empty", 32'(exp_q.size()), 32'd0);

    // 3. Wrap and op coverage, streamed back-to-back
    applyStimulus(1'b1, 8'hFF, 8'h02, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1); step();
    applyStimulus(1'b1, 8'h0F, 8'h3C, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1); step();
    applyStimulus(1'b1, 8'h00, 8'h01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1); step();
    checkOutput("stream_count", 32'(count_o), 32'd3);
    checkOutput("stream_first", 32'(res_o), 32'h02);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stream_valid", 32'(valid_o), 32'd1);
      idle(1'b1);
    end
    checkOutput("stream_done", 32'(valid_o), 32'd0);
    checkOutput("stream_empty", 32'(exp_q.size()), 32'd0);

    // 4. Backpressure: offer five items with ready_i low
    for (int i = 0; i < 5; i++) begin
      ia[i] = 8'($urandom);
      ib[i] = 8'($urandom);
      sa[i] = 2'($urandom_range(0, 3));
      sb[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ia[i], ib[i], sa[i], sb[i], 1'b0, 1'b0, 1'b1);
      step();
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_accepted", 32'(exp_q.size()), 32'd3);
    checkOutput("bp_count", 32'(count_o), 32'd3);
    checkOutput("bp_ready", 32'(ready_o), 32'd0);
    checkOutput("bp_valid", 32'(valid_o), 32'd1);
    checkOutput("bp_head", 32'(res_o), 32'(refResult(ia[0], ib[0], sa[0], sb[0])));
    for (int i = 0; i < 2; i++) begin
      idle(1'b0);
      checkOutput("bp_stable", 32'(res_o), 32'(refResult(ia[0], ib[0], sa[0], sb[0])));
    end
    drain("bp_drain", 10);
    checkOutput("bp_idle", 32'(valid_o), 32'd0);

    // 5. Flush with three in flight and valid_i high
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 8'h01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      step();
    end
    checkOutput("fl_pre_count", 32'(count_o), 32'd3);
    applyStimulus(1'b1, 8'h77, 8'h01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    checkOutput("fl_ready", 32'(ready_o), 32'd0);
    step();
    checkOutput("fl_count", 32'(count_o), 32'd0);
    checkOutput("fl_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    checkOutput("fl_after", 32'(valid_o), 32'd0);

    // 6. Reset mid-stream with two in flight
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'h40 + 8'(i), 8'h04, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1);
      step();
    end
    checkOutput("mr_pre_count", 32'(count_o), 32'd2);
    applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("mr_valid", 32'(valid_o), 32'd0);
    checkOutput("mr_count", 32'(count_o), 32'd0);
    checkOutput("mr_res", 32'(res_o), 32'd0);
    applyStimulus(1'b1, 8'h81, 8'hFF, 2'b01, 2'b11, 1'b1, 1'b0, 1'b1);
    checkOutput("mr_ready", 32'(ready_o), 32'd1);
    step();
    idle(1'b1);
    checkOutput("mr_lat1", 32'(valid_o), 32'd0);
    idle(1'b1);
    checkOutput("mr_lat2", 32'(valid_o), 32'd1);
    checkOutput("mr_result", 32'(res_o), 32'h03);
    drain("mr_drain", 5);
    checkOutput("mr_idle", 32'(valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
